// File: rtl/player_pkg.sv
// Shared definitions for the player position and punch controller blocks.
// Screen geometry constants and the position-state encoding live here.
package player_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        LUNGE  = 2'd2,
        RECOIL = 2'd3
    } pos_state_t;

    localparam int SCREEN_X_MIN = 0;
    localparam int SCREEN_X_MAX = 637;
    localparam int SPRITE_W     = 125;

endpackage

// File: rtl/frame_tick.sv
// Rising-edge detector turning the vertical-sync level into a one-clk frame tick.
// The level is assumed synchronous to clk.
module frame_tick (
    input  logic clk,
    input  logic Reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) level_q <= 1'b0;
        else       level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/player2_position.sv
// Per-frame X-position integrator for player 2: walk, lunge and recoil motion
// with wall/opponent clamping, plus a single landed-punch report per lunge.
module player2_position
    import player_pkg::*;
#(
    parameter int X_MIN         = SCREEN_X_MIN,
    parameter int X_MAX         = SCREEN_X_MAX,
    parameter int SPRITE_W      = player_pkg::SPRITE_W,
    parameter int X_INIT        = 400,
    parameter int WALK_STEP     = 2,
    parameter int RECOIL_STEP   = 4,
    parameter int RECOIL_FRAMES = 6
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               walk_left,
    input  logic               walk_right,
    input  logic               punch_active,
    input  logic signed [31:0] punch_motion,
    input  logic [31:0]        opp_xpos,
    input  logic               hit_in,
    output logic [31:0]        Xpos,
    output logic               hit_out,
    output pos_state_t         state
);

    localparam logic [3:0] RC_INIT = 4'(RECOIL_FRAMES - 1);

    logic               tick;
    logic               hit_pend;
    logic               hit_now;
    logic               hit_done;
    logic               hit_done_n;
    logic               hit_fire;
    logic [3:0]         rc_cnt;
    logic [3:0]         rc_n;
    logic signed [31:0] x_q;
    logic signed [31:0] x_n;
    logic signed [31:0] cand;
    logic signed [31:0] opp_s;
    pos_state_t         state_n;

    frame_tick u_frame_tick (
        .clk   (clk),
        .Reset (Reset),
        .level (frame_clk),
        .pulse (tick)
    );

    // Upper bound is the nearer of the right wall and the opponent's left edge;
    // the lower bound is applied last so it wins when the range is empty.
    function automatic logic signed [31:0] clamp_x(input logic signed [31:0] c,
                                                   input logic signed [31:0] opp);
        logic signed [31:0] hi;
        logic signed [31:0] res;
        hi = X_MAX - SPRITE_W;
        if (opp - SPRITE_W < hi) hi = opp - SPRITE_W;
        res = c;
        if (res > hi)    res = hi;
        if (res < X_MIN) res = X_MIN;
        return res;
    endfunction

    assign opp_s   = signed'(opp_xpos);
    assign hit_now = hit_pend | hit_in;

    // NOTE: every signal driven here gets a default first, so no latches are inferred.
    always_comb begin
        state_n    = state;
        x_n        = x_q;
        rc_n       = rc_cnt;
        cand       = x_q;
        hit_fire   = 1'b0;
        hit_done_n = hit_done;
        if (tick) begin
            if (hit_now) begin
                state_n = RECOIL;
                rc_n    = RC_INIT;
                cand    = x_q - RECOIL_STEP;
                x_n     = clamp_x(cand, opp_s);
            end else if (state == RECOIL && rc_cnt != 4'd0) begin
                rc_n = rc_cnt - 4'd1;
                cand = x_q - RECOIL_STEP;
                x_n  = clamp_x(cand, opp_s);
            end else if (punch_active) begin
                state_n = LUNGE;
                cand    = x_q + punch_motion;
                x_n     = clamp_x(cand, opp_s);
            end else if (walk_left ^ walk_right) begin
                state_n = WALK;
                cand    = walk_left ? x_q - WALK_STEP : x_q + WALK_STEP;
                x_n     = clamp_x(cand, opp_s);
            end else begin
                state_n = IDLE;
            end

            // Contact is judged on the unclamped edge, since clamping stops at the opponent.
            if (state_n == LUNGE) begin
                if (!hit_done && (cand + SPRITE_W >= opp_s)) begin
                    hit_fire   = 1'b1;
                    hit_done_n = 1'b1;
                end
            end else begin
                hit_done_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            x_q      <= X_INIT;
            state    <= IDLE;
            rc_cnt   <= '0;
            hit_pend <= 1'b0;
            hit_done <= 1'b0;
            hit_out  <= 1'b0;
        end else begin
            x_q      <= x_n;
            state    <= state_n;
            rc_cnt   <= rc_n;
            hit_done <= hit_done_n;
            hit_out  <= hit_fire;
            hit_pend <= tick ? 1'b0 : (hit_pend | hit_in);
        end
    end

    assign Xpos = x_q;

endmodule

// File: tb/tb_player2_position.sv
// Self-checking bench for player2_position: directed vector table, hand-written
// reset/tick corner cases, and randomized ticks against a behavioural model.
module tb_player2_position;
    import player_pkg::*;

    logic               clk = 1'b0;
    logic               Reset = 1'b1;
    logic               frame_clk = 1'b0;
    logic               walk_left = 1'b0;
    logic               walk_right = 1'b0;
    logic               punch_active = 1'b0;
    logic signed [31:0] punch_motion = '0;
    logic [31:0]        opp_xpos = 32'd1000;
    logic               hit_in = 1'b0;
    logic [31:0]        Xpos;
    logic               hit_out;
    pos_state_t         state;

    int n_checks = 0;
    int n_errors = 0;

    player2_position dut (
        .clk          (clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .walk_left    (walk_left),
        .walk_right   (walk_right),
        .punch_active (punch_active),
        .punch_motion (punch_motion),
        .opp_xpos     (opp_xpos),
        .hit_in       (hit_in),
        .Xpos         (Xpos),
        .hit_out      (hit_out),
        .state        (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit wl, wr, pa;
        int motion, opp;
        bit hb;
        int ex, es;
        bit eh;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit wl, bit wr, bit pa, int motion, int opp, bit hb,
                                int ex, int es, bit eh);
        vec_t v;
        v.wl = wl; v.wr = wr; v.pa = pa; v.motion = motion; v.opp = opp; v.hb = hb;
        v.ex = ex; v.es = es; v.eh = eh;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: recoil is tracked as the last tick number it covers.
    int m_x, m_state, m_tick, m_recoil_last;
    bit m_reported;

    function automatic void model_reset();
        m_x = 400; m_state = 0; m_tick = 0; m_recoil_last = 0; m_reported = 0;
    endfunction

    function automatic void model_tick(bit wl, bit wr, bit pa, int motion, int opp, bit hit,
                                       output bit eh);
        int cand, hi;
        bit moved;
        m_tick++;
        eh = 0;
        moved = 1;
        cand = m_x;
        if (hit) m_recoil_last = m_tick + 6 - 1;
        if (m_tick <= m_recoil_last) begin m_state = 3; cand = m_x - 4; end
        else if (pa)                 begin m_state = 2; cand = m_x + motion; end
        else if (wl != wr)           begin m_state = 1; cand = wl ? m_x - 2 : m_x + 2; end
        else                         begin m_state = 0; moved = 0; end
        if (m_state == 2) begin
            if (!m_reported && cand + 125 >= opp) begin eh = 1; m_reported = 1; end
        end else begin
            m_reported = 0;
        end
        if (moved) begin
            hi = (opp - 125 < 512) ? opp - 125 : 512;
            m_x = (cand > hi) ? hi : cand;
            if (m_x < 0) m_x = 0;
        end
    endfunction

    task automatic pulse_hit();
        @(negedge clk); hit_in = 1'b1;
        @(negedge clk); hit_in = 1'b0;
    endtask

    // One frame: raise frame_clk, check right after the tick edge, then check
    // that hit_out drops and Xpos holds on the following non-tick edge.
    task automatic do_tick(input bit wl, input bit wr, input bit pa, input int motion,
                           input int opp, input bit hit_same,
                           input int ex, input int es, input bit eh, input string tag);
        @(negedge clk);
        walk_left = wl; walk_right = wr; punch_active = pa;
        punch_motion = motion; opp_xpos = opp; hit_in = hit_same; frame_clk = 1'b1;
        @(posedge clk); #1;
        hit_in = 1'b0;
        check({tag, " xpos"}, int'(Xpos), ex);
        check({tag, " state"}, int'(state), es);
        check({tag, " hit_out"}, int'(hit_out), int'(eh));
        @(negedge clk); frame_clk = 1'b0;
        @(posedge clk); #1;
        check({tag, " hit_out_drop"}, int'(hit_out), 0);
        check({tag, " hold_xpos"}, int'(Xpos), ex);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        Reset = 1'b1;
        #1;
        check("reset xpos", int'(Xpos), 400);
        check("reset state", int'(state), int'(IDLE));
        check("reset hit_out", int'(hit_out), 0);
        walk_left = 0; walk_right = 0; punch_active = 0; punch_motion = 0;
        hit_in = 0; frame_clk = 0; opp_xpos = 1000;
        @(negedge clk);
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        // Directed vector table covering the main motion rules and boundaries.
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1000, 0, 400, IDLE, 0);
        for (int i = 1; i <= 10; i++) add(0, 1, 0, 0, 1000, 0, 400 + 2 * i, WALK, 0);
        add(1, 1, 0, 0, 1000, 0, 420, IDLE, 0);
        add(0, 0, 1, 85, 1000, 0, 505, LUNGE, 0);
        add(0, 0, 1, 7, 1000, 0, 512, LUNGE, 0);
        add(0, 0, 1, -112, 1000, 0, 400, LUNGE, 0);
        add(0, 0, 0, 0, 1000, 0, 400, IDLE, 0);
        add(0, 0, 1, 7, 530, 0, 405, LUNGE, 1);
        add(0, 0, 1, 7, 530, 0, 405, LUNGE, 0);
        add(0, 0, 1, 5, 530, 0, 405, LUNGE, 0);
        add(0, 0, 1, -395, 1000, 0, 10, LUNGE, 0);
        add(0, 0, 0, 0, 1000, 0, 10, IDLE, 0);
        add(0, 0, 0, 0, 1000, 1, 6, RECOIL, 0);
        add(0, 0, 0, 0, 1000, 0, 2, RECOIL, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1000, 0, 0, RECOIL, 0);
        add(0, 0, 0, 0, 1000, 0, 0, IDLE, 0);
        add(0, 0, 1, 100, 1000, 0, 100, LUNGE, 0);
        add(0, 0, 0, 0, 1000, 0, 100, IDLE, 0);
        add(0, 0, 0, 0, 1000, 1, 96, RECOIL, 0);
        add(0, 0, 0, 0, 1000, 0, 92, RECOIL, 0);
        add(0, 0, 0, 0, 1000, 1, 88, RECOIL, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 1, 50, 1000, 0, 88 - 4 * i, RECOIL, 0);
        add(0, 0, 0, 0, 1000, 0, 68, IDLE, 0);
        add(1, 0, 0, 0, 1000, 0, 66, WALK, 0);
        add(0, 0, 1, -100, 1000, 0, 0, LUNGE, 0);

        apply_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].hb) pulse_hit();
            do_tick(vecs[i].wl, vecs[i].wr, vecs[i].pa, vecs[i].motion, vecs[i].opp, 1'b0,
                    vecs[i].ex, vecs[i].es, vecs[i].eh, $sformatf("vec%0d", i));
        end

        // frame_clk held high for several cycles gives exactly one tick.
        apply_reset();
        @(negedge clk); walk_right = 1'b1; frame_clk = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("held_frame xpos", int'(Xpos), 402);
        check("held_frame state", int'(state), int'(WALK));
        @(negedge clk); frame_clk = 1'b0; walk_right = 1'b0;

        // hit_in coinciding with the tick is consumed by that tick.
        do_tick(0, 0, 0, 0, 1000, 1'b1, 398, RECOIL, 0, "same_cycle_hit");

        // Reset mid-recoil with a hit pending abandons both.
        pulse_hit();
        @(negedge clk); Reset = 1'b1;
        #1;
        check("midreset xpos", int'(Xpos), 400);
        check("midreset state", int'(state), int'(IDLE));
        check("midreset hit_out", int'(hit_out), 0);
        @(negedge clk); Reset = 1'b0;
        do_tick(0, 0, 0, 0, 1000, 1'b0, 400, IDLE, 0, "post_reset");

        // Randomized ticks against the behavioural model.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            bit wl, wr, pa, hb, hs, eh;
            int motion, opp;
            wl = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            pa = ($urandom_range(0, 3) == 0);
            motion = $urandom_range(0, 40) - 20;
            opp = $urandom_range(300, 900);
            hb = ($urandom_range(0, 15) == 0);
            hs = ($urandom_range(0, 15) == 0);
            if (hb) pulse_hit();
            model_tick(wl, wr, pa, motion, opp, hb | hs, eh);
            do_tick(wl, wr, pa, motion, opp, hs, m_x, m_state, eh, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
